zion_riscv_isa_lib_bj_redirect: RTL and testbench

ZION_RISCV_ISA_LIB_BJ_REDIRECT -- requirements
Module: zion_riscv_isa_lib_bj_redirect

---
 rtl/zion_riscv_isa_lib_bj_redirect.sv | 118 +++++++++++
 tb/tb_zion_riscv_isa_lib_bj_redirect.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/zion_riscv_isa_lib_bj_redirect.sv
// Branch/jump redirect unit: steers the fetch PC on taken branches, holds fetch
// off for FLUSH_CYCLES after a redirect and raises a trap on misaligned targets.
module zion_riscv_isa_lib_bj_redirect #(
  parameter int          RV64         = 0,
  parameter logic [63:0] RESET_PC     = 64'h0,
  parameter int          FLUSH_CYCLES = 2,
  localparam int         CPU_WIDTH    = 32*(RV64+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iExVld,
  input  logic [1:0]           iBjEn,
  input  logic [CPU_WIDTH-1:0] iTgtAddr,
  input  logic [CPU_WIDTH-1:0] iExPc,
  input  logic                 iFetchRdy,
  input  logic                 iTrapAck,
  input  logic [CPU_WIDTH-1:0] iTrapVec,
  output logic                 oFetchVld,
  output logic [CPU_WIDTH-1:0] oFetchPc,
  output logic                 oFlush,
  output logic                 oMisalign,
  output logic [CPU_WIDTH-1:0] oMisalignPc,
  output logic [31:0]          oRedirectCnt
);

  typedef enum logic [1:0] {RUN, FLUSH, TRAP} state_t;

  localparam logic [CPU_WIDTH-1:0] RESET_PC_W = RESET_PC[CPU_WIDTH-1:0];

  state_t               r_state, w_state_nxt;
  logic [CPU_WIDTH-1:0] r_pc, w_pc_nxt;
  logic [CPU_WIDTH-1:0] r_mis_pc, w_mis_pc_nxt;
  logic                 r_flush, w_flush_nxt;
  logic                 r_mis, w_mis_nxt;
  logic [3:0]           r_flush_cnt, w_flush_cnt_nxt;
  logic [31:0]          r_redirect_cnt, w_redirect_cnt_nxt;
  logic                 w_taken;
  logic                 w_aligned;
  logic                 w_fetch_hs;

  assign w_taken    = iExVld & (iBjEn[1] | iBjEn[0]);
  assign w_aligned  = (iTgtAddr[1:0] == 2'b00);
  assign w_fetch_hs = (r_state == RUN) & iFetchRdy;

  always_comb begin
    w_state_nxt        = r_state;
    w_pc_nxt           = r_pc;
    w_mis_pc_nxt       = r_mis_pc;
    w_flush_nxt        = 1'b0;
    w_mis_nxt          = r_mis;
    w_flush_cnt_nxt    = r_flush_cnt;
    w_redirect_cnt_nxt = r_redirect_cnt;
    case (r_state)
      RUN: begin
        // A taken branch wins over a same-cycle sequential fetch advance
        if (w_taken) begin
          w_flush_nxt = 1'b1;
          if (w_aligned) begin
            w_pc_nxt           = iTgtAddr;
            w_state_nxt        = FLUSH;
            w_flush_cnt_nxt    = 4'(FLUSH_CYCLES - 1);
            w_redirect_cnt_nxt = (r_redirect_cnt == 32'hFFFF_FFFF) ?
                                 r_redirect_cnt : r_redirect_cnt + 32'd1;
          end else begin
            w_state_nxt  = TRAP;
            w_mis_nxt    = 1'b1;
            w_mis_pc_nxt = iExPc;
          end
        end else if (w_fetch_hs) begin
          w_pc_nxt = r_pc + CPU_WIDTH'(4);
        end
      end
      FLUSH: begin
        if (r_flush_cnt == 4'd0) begin
          w_state_nxt = RUN;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - 4'd1;
        end
      end
      TRAP: begin
        if (iTrapAck) begin
          w_pc_nxt    = iTrapVec;
          w_mis_nxt   = 1'b0;
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= RUN;
      r_pc           <= RESET_PC_W;
      r_mis_pc       <= '0;
      r_flush        <= 1'b0;
      r_mis          <= 1'b0;
      r_flush_cnt    <= 4'd0;
      r_redirect_cnt <= 32'd0;
    end else begin
      r_state        <= w_state_nxt;
      r_pc           <= w_pc_nxt;
      r_mis_pc       <= w_mis_pc_nxt;
      r_flush        <= w_flush_nxt;
      r_mis          <= w_mis_nxt;
      r_flush_cnt    <= w_flush_cnt_nxt;
      r_redirect_cnt <= w_redirect_cnt_nxt;
    end
  end

  assign oFetchVld    = (r_state == RUN);
  assign oFetchPc     = r_pc;
  assign oFlush       = r_flush;
  assign oMisalign    = r_mis;
  assign oMisalignPc  = r_mis_pc;
  assign oRedirectCnt = r_redirect_cnt;

endmodule

// File: tb/tb_zion_riscv_isa_lib_bj_redirect.sv
// Bench for the branch/jump redirect unit: directed scenarios followed by
// random traffic, all compared against a cycle-level behavioural model.
module tb_zion_riscv_isa_lib_bj_redirect;

  localparam int FLUSH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        iExVld;
  logic [1:0]  iBjEn;
  logic [31:0] iTgtAddr;
  logic [31:0] iExPc;
  logic        iFetchRdy;
  logic        iTrapAck;
  logic [31:0] iTrapVec;
  logic        oFetchVld;
  logic [31:0] oFetchPc;
  logic        oFlush;
  logic        oMisalign;
  logic [31:0] oMisalignPc;
  logic [31:0] oRedirectCnt;

  int total = 0;
  int bad   = 0;

  // Reference model state: fetch is blocked while m_blk > 0 or a trap is pending
  logic [31:0] m_pc;
  int          m_blk;
  bit          m_trap;
  bit          m_flush;
  logic [31:0] m_mpc;
  longint      m_cnt;

  zion_riscv_isa_lib_bj_redirect #(
    .RV64(0), .RESET_PC(64'h0), .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .iExVld(iExVld), .iBjEn(iBjEn), .iTgtAddr(iTgtAddr),
    .iExPc(iExPc), .iFetchRdy(iFetchRdy), .iTrapAck(iTrapAck), .iTrapVec(iTrapVec),
    .oFetchVld(oFetchVld), .oFetchPc(oFetchPc), .oFlush(oFlush),
    .oMisalign(oMisalign), .oMisalignPc(oMisalignPc), .oRedirectCnt(oRedirectCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc = 32'h0; m_blk = 0; m_trap = 0; m_flush = 0; m_mpc = 32'h0; m_cnt = 0;
  endfunction

  function automatic void model_step();
    bit taken;
    taken   = iExVld && (iBjEn != 2'b00);
    m_flush = 0;
    if (m_trap) begin
      if (iTrapAck) begin
        m_pc   = iTrapVec;
        m_trap = 0;
      end
    end else if (m_blk > 0) begin
      m_blk--;
    end else if (taken) begin
      m_flush = 1;
      if (iTgtAddr % 4 == 0) begin
        m_pc  = iTgtAddr;
        m_blk = FLUSH_CYCLES;
        if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
      end else begin
        m_trap = 1;
        m_mpc  = iExPc;
      end
    end else if (iFetchRdy) begin
      m_pc = 32'((64'(m_pc) + 4) % 64'h1_0000_0000);
    end
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".vld"},  oFetchVld,    (!m_trap && m_blk == 0));
    chk({tag, ".pc"},   oFetchPc,     m_pc);
    chk({tag, ".fl"},   oFlush,       m_flush);
    chk({tag, ".mis"},  oMisalign,    m_trap);
    chk({tag, ".mpc"},  oMisalignPc,  m_mpc);
    chk({tag, ".cnt"},  oRedirectCnt, m_cnt[31:0]);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic set_in(input bit vld, input logic [1:0] en, input logic [31:0] tgt,
                        input logic [31:0] pc, input bit rdy, input bit ack,
                        input logic [31:0] vec);
    iExVld = vld; iBjEn = en; iTgtAddr = tgt; iExPc = pc;
    iFetchRdy = rdy; iTrapAck = ack; iTrapVec = vec;
  endtask

  // Asserts reset between edges and checks outputs before any clock edge occurs
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [31:0] tgt;
    rst = 1'b1;
    set_in(0, 2'b00, 0, 0, 1, 0, 0);
    model_reset();
    #3;
    check_all("rst");
    @(negedge clk);
    rst = 1'b0;

    // Sequential fetch
    check_all("seq0");
    for (int i = 0; i < 3; i++) tick("seq");

    // Taken redirect with a simultaneous handshake
    set_in(1, 2'b10, 32'h100, 32'h0C, 1, 0, 0);
    tick("tkn");
    set_in(1, 2'b10, 32'h200, 32'h0, 1, 0, 0);
    tick("tkfl");
    set_in(0, 2'b00, 0, 0, 1, 0, 0);
    tick("fl2");
    tick("run");

    // Misaligned target, trap held while taken/ack-less cycles pass
    set_in(1, 2'b01, 32'h102, 32'h80, 1, 0, 0);
    tick("mis");
    set_in(1, 2'b10, 32'h300, 32'h0, 1, 0, 0);
    tick("trap1");
    tick("trap2");
    set_in(0, 2'b00, 0, 0, 1, 1, 32'h400);
    tick("ack");

    // Ack outside TRAP has no effect
    set_in(0, 2'b00, 0, 0, 0, 1, 32'h800);
    tick("ackrun");

    // PC wrap-around
    set_in(1, 2'b11, 32'hFFFF_FFFC, 0, 0, 0, 0);
    tick("wtk");
    set_in(0, 2'b00, 0, 0, 1, 0, 0);
    for (int i = 0; i < FLUSH_CYCLES; i++) tick("wfl");
    tick("wrap");

    // Reset in the middle of FLUSH and of TRAP
    set_in(1, 2'b10, 32'h500, 0, 1, 0, 0);
    tick("pre_rf");
    set_in(0, 2'b00, 0, 0, 1, 0, 0);
    async_reset("rstfl");
    tick("postrf");
    set_in(1, 2'b10, 32'h501, 32'h44, 1, 0, 0);
    tick("pre_rt");
    set_in(0, 2'b00, 0, 0, 1, 0, 0);
    async_reset("rsttr");
    tick("postrt");

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      tgt = $urandom;
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      set_in($urandom_range(0, 2) == 0, 2'($urandom), tgt, $urandom,
             $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom);
      if ($urandom_range(0, 199) == 0) async_reset("rrst");
      else tick("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
